// File: rtl/emergency_preempt_arbiter.sv
// Emergency-vehicle preemption arbiter: round-robin grant of one approach at a time,
// sequenced through all-red clearance, bounded hold and a recovery gap.
module emergency_preempt_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned TW       = 5,
    parameter int unsigned CLR_T    = 3,
    parameter int unsigned MIN_HOLD = 5,
    parameter int unsigned MAX_HOLD = 30,
    parameter int unsigned REC_T    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [N-1:0] req,
    input  logic         ped_btn,
    input  logic         ped_ack,
    output logic [N-1:0] grant,
    output logic         preempt_main,
    output logic         preempt_side,
    output logic         all_red,
    output logic         ped_req,
    output logic [1:0]   state_o
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    localparam logic [TW-1:0] ClrT    = TW'(CLR_T);
    localparam logic [TW-1:0] MinHold = TW'(MIN_HOLD);
    localparam logic [TW-1:0] MaxHold = TW'(MAX_HOLD);
    localparam logic [TW-1:0] RecT    = TW'(REC_T);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StClear   = 2'd1,
        StHold    = 2'd2,
        StRecover = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] sel_q, sel_d;
    logic          ped_q, ped_d;

    logic [TW-1:0] timer_inc;
    logic [PW-1:0] pick;
    logic [PW-1:0] sel_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            ped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            ped_q   <= ped_d;
        end
    end

    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    assign sel_next  = (32'(sel_q) == N - 1) ? '0 : sel_q + 1'b1;

    // Round-robin scan starting at ptr_q, wrapping past N-1 to 0.
    always_comb begin
        int unsigned idx;
        logic        found;
        pick  = sel_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr_q) + i) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    sel_d   = pick;
                    state_d = StClear;
                end
            end
            StClear: begin
                if (tick && timer_inc == ClrT) begin
                    state_d = req[sel_q] ? StHold : StRecover;
                end
            end
            StHold: begin
                if ((!req[sel_q] && timer_q >= MinHold) || timer_q >= MaxHold) begin
                    state_d = StRecover;
                    ptr_d   = sel_next;
                end
            end
            StRecover: begin
                if (tick && timer_inc == RecT) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Timer restarts on every state change; IDLE ignores tick.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (tick && state_q != StIdle) begin
            timer_d = timer_inc;
        end
    end

    // A press in the same cycle as an acknowledge wins.
    always_comb begin
        ped_d = ped_q;
        if (ped_btn) begin
            ped_d = 1'b1;
        end else if (ped_ack) begin
            ped_d = 1'b0;
        end
    end

    always_comb begin
        grant        = '0;
        preempt_main = 1'b0;
        preempt_side = 1'b0;
        if (state_q == StHold) begin
            grant[sel_q] = 1'b1;
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (i % 2 == 0) begin
                preempt_main = preempt_main | grant[i];
            end else begin
                preempt_side = preempt_side | grant[i];
            end
        end
    end

    assign all_red = (state_q == StClear);
    assign ped_req = ped_q;
    assign state_o = state_q;

    a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_red_vs_grant : assert property (@(posedge clk) disable iff (rst) !(all_red && |grant));
    a_main_vs_side : assert property (@(posedge clk) disable iff (rst)
                                      !(preempt_main && preempt_side));

endmodule

// File: tb/tb_emergency_preempt_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared every cycle
// against a behavioural model of the preemption sequence.
module tb_emergency_preempt_arbiter;

    localparam int N        = 4;
    localparam int CLR_T    = 3;
    localparam int MIN_HOLD = 5;
    localparam int MAX_HOLD = 30;
    localparam int REC_T    = 2;
    localparam int TMAX     = 31;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       ped_btn = 1'b0;
    logic       ped_ack = 1'b0;
    logic [3:0] grant;
    logic       preempt_main;
    logic       preempt_side;
    logic       all_red;
    logic       ped_req;
    logic [1:0] state_o;

    emergency_preempt_arbiter #(
        .N(N), .TW(5), .CLR_T(CLR_T), .MIN_HOLD(MIN_HOLD), .MAX_HOLD(MAX_HOLD), .REC_T(REC_T)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .req(req), .ped_btn(ped_btn), .ped_ack(ped_ack),
        .grant(grant), .preempt_main(preempt_main), .preempt_side(preempt_side),
        .all_red(all_red), .ped_req(ped_req), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    bit rand_mode = 1'b0;
    bit chk_en = 1'b0;

    // Model: 0 idle, 1 clearance, 2 hold, 3 recovery.
    int m_state, m_sel, m_ptr, m_timer;
    bit m_ped;
    bit m_valid = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(posedge clk) begin : model
        int ns;
        if (rst) begin
            m_state = 0; m_sel = 0; m_ptr = 0; m_timer = 0; m_ped = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            ns = m_state;
            case (m_state)
                0: if (req != 0) begin
                    // Scan backwards so the last hit is the first in round-robin order.
                    for (int i = N - 1; i >= 0; i--)
                        if (req[(m_ptr + i) % N]) m_sel = (m_ptr + i) % N;
                    ns = 1;
                end
                1: if (tick && m_timer + 1 == CLR_T) ns = req[m_sel] ? 2 : 3;
                2: if ((!req[m_sel] && m_timer >= MIN_HOLD) || m_timer >= MAX_HOLD) begin
                    ns = 3;
                    m_ptr = (m_sel + 1) % N;
                end
                default: if (tick && m_timer + 1 == REC_T) ns = 0;
            endcase
            if (ns != m_state) m_timer = 0;
            else if (tick && m_state != 0 && m_timer < TMAX) m_timer++;
            m_state = ns;
            if (ped_btn) m_ped = 1'b1;
            else if (ped_ack) m_ped = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && m_valid) begin
            check("state_o", int'(state_o), m_state);
            check("grant", int'(grant), (m_state == 2) ? (1 << m_sel) : 0);
            check("preempt_main", int'(preempt_main), int'(m_state == 2 && m_sel % 2 == 0));
            check("preempt_side", int'(preempt_side), int'(m_state == 2 && m_sel % 2 == 1));
            check("all_red", int'(all_red), int'(m_state == 1));
            check("ped_req", int'(ped_req), int'(m_ped));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        ped_btn = 1'b0;
        ped_ack = 1'b0;
        if (rand_mode) tick = ($urandom_range(0, 2) == 0);
        else tick = (cyc % 4 == 0);
    endtask

    task automatic wait_state(input int st, input int budget, input string name);
        int n = 0;
        while (int'(state_o) != st && n < budget) begin
            step();
            n++;
        end
        check(name, int'(state_o), st);
    endtask

    task automatic hold_len(output int n);
        n = 0;
        while (state_o == 2'd2 && n < 300) begin
            step();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit seen;
        repeat (3) step();
        check("reset state_o", int'(state_o), 0);
        check("reset grant", int'(grant), 0);
        check("reset all_red", int'(all_red), 0);
        check("reset ped_req", int'(ped_req), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Continuous 0101 from ptr=0: index 0 for MAX_HOLD, then index 2.
        req = 4'b0101;
        wait_state(2, 100, "t2 hold0");
        check("t2 grant0", int'(grant), 4'b0001);
        hold_len(n);
        check("t2 hold cycles", n, 4 * MAX_HOLD + 1);
        wait_state(2, 100, "t2 hold2");
        check("t2 grant2", int'(grant), 4'b0100);
        req = 4'b0000;
        wait_state(0, 200, "t2 idle");

        // ptr now 3: index 3 first, then wrap to 0.
        req = 4'b1001;
        wait_state(2, 100, "t6 hold3");
        check("t6 grant3", int'(grant), 4'b1000);
        hold_len(n);
        wait_state(2, 100, "t6 hold0");
        check("t6 grant0", int'(grant), 4'b0001);
        req = 4'b0000;
        wait_state(0, 300, "t6 idle");

        // Side-street request dropped after 2 ticks: grant still lasts MIN_HOLD ticks.
        req = 4'b0010;
        step();
        check("t1 all_red", int'(all_red), 1);
        wait_state(2, 100, "t1 hold");
        check("t1 grant", int'(grant), 4'b0010);
        check("t1 side", int'(preempt_side), 1);
        check("t1 main", int'(preempt_main), 0);
        repeat (8) step();
        req = 4'b0000;
        hold_len(n);
        check("t1 hold cycles", n + 8, 4 * MIN_HOLD + 1);
        wait_state(3, 10, "t1 recover");
        wait_state(0, 100, "t1 idle");

        // One-clock pulse: clearance runs, no grant ever.
        req = 4'b1000;
        step();
        req = 4'b0000;
        check("t3 clear", int'(state_o), 1);
        seen = 1'b0;
        n = 0;
        while (state_o != 2'd3 && n < 100) begin
            seen = seen | (|grant);
            step();
            n++;
        end
        check("t3 recover", int'(state_o), 3);
        check("t3 no grant", int'(seen), 0);
        wait_state(0, 100, "t3 idle");

        // Pedestrian latch.
        ped_btn = 1'b1;
        step();
        check("t4 set", int'(ped_req), 1);
        ped_btn = 1'b1;
        ped_ack = 1'b1;
        step();
        check("t4 both", int'(ped_req), 1);
        ped_ack = 1'b1;
        step();
        check("t4 ack", int'(ped_req), 0);

        // Reset mid-hold, then re-arbitration from index 0.
        req = 4'b0101;
        wait_state(2, 100, "t5 hold");
        check("t5 grant2", int'(grant), 4'b0100);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5 rst state", int'(state_o), 0);
        check("t5 rst grant", int'(grant), 0);
        wait_state(2, 100, "t5 rehold");
        check("t5 grant0", int'(grant), 4'b0001);
        req = 4'b0000;
        wait_state(0, 300, "t5 idle");

        // Randomized traffic against the model.
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 19) == 0) req = 4'($urandom_range(0, 15));
            ped_btn = ($urandom_range(0, 15) == 0);
            ped_ack = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 499) == 0);
        end
        rst = 1'b0;
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
